// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Bit-serial add/subtract controller. It drives one bit per cycle,
//            LSB first, into a shared external full adder and collects the
//            sum and carry that come back. It produces the WIDTH-bit result,
//            the final carry-out and the two's-complement overflow.
// Ports    : iClk, iRst        - clock; synchronous active-high reset
//            iStart, iSub      - start request; 0 = A+B, 1 = A-B (IDLE only)
//            iA, iB            - operands, captured when the start is accepted
//            oFaA, oFaB, oFaC  - operand bits and carry-in sent to the adder
//            iFaS, iFaC        - sum and carry-out returned by the adder
//            oBusy, oDone      - operation in progress / one-cycle result strobe
//            oSum, oCout, oOvf - result, final carry-out, signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iSub,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oFaA,
  output logic             oFaB,
  output logic             oFaC,
  input  logic             iFaS,
  input  logic             iFaC,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oCout,
  output logic             oOvf
);

  localparam int                 c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;      // already inverted for subtraction
  logic [WIDTH-1:0]   r_sum;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic               w_run;

  // Adder inputs come only from registers, so the external adder never
  // closes a combinational loop through this block.
  assign w_run = (r_state == S_RUN);
  assign oFaA  = w_run & r_a[r_idx];
  assign oFaB  = w_run & r_b[r_idx];
  assign oFaC  = w_run & r_carry;

  assign oSum  = r_sum;
  assign oCout = r_cout;
  assign oOvf  = r_ovf;
  assign oBusy = r_busy;
  assign oDone = r_done;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (iStart) begin
            // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
            r_a     <= iA;
            r_b     <= iSub ? ~iB : iB;
            r_carry <= iSub;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= iFaS;
          r_carry      <= iFaC;
          if (r_idx == c_LAST) begin
            // r_carry still holds the carry into the MSB at this edge.
            r_cout  <= iFaC;
            r_ovf   <= r_carry ^ iFaC;
            r_idx   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + c_IDX_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
